hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage CPU. It generates the write-enable and flush controls consumed by the PC register, the IF/ID pipeline register and the ID/EX pipeline register. It resolves three hazard classes: load-use data hazards, taken branches/jumps resolved in ID, and multi-cycle multiply occupancy of EX. It also keeps saturating performance counters for stall and flush cycles.

## Interface
Parameters:
- MUL_LAT, 4, total EX cycles a multiply occupies (legal range 2..15)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  pipeline clock
- rst_i  in  1  synchronous, active-high reset
- IFID_rs_i  in  5  rs field of instruction in ID
- IFID_rt_i  in  5  rt field of instruction in ID
- IDEX_MemRead_i  in  1  instruction in EX is a load
- IDEX_rt_i  in  5  destination of the load in EX
- Branch_taken_i  in  1  branch in ID resolved taken
- Jump_i  in  1  jump in ID
- Mul_start_i  in  1  instruction in ID is a multiply
- PC_Write_o  out  1  PC load enable
- IFID_Write_o  out  1  IF/ID load enable
- Flush_o  out  1  clear IF/ID to 32'b0
- IDEX_Bubble_o  out  1  zero ID/EX control fields this edge
- IDEX_Hold_o  out  1  hold ID/EX contents (EX occupied)
- stall_cnt_o  out  CNT_W  cycles with PC_Write_o=0 since reset
- flush_cnt_o  out  CNT_W  cycles with Flush_o=1 since reset

## Operation
- Outputs are combinational from the registered state and the current inputs, so they are valid before the same posedge that IF/ID samples.
- load_use = IDEX_MemRead_i && IDEX_rt_i!=0 && (IDEX_rt_i==IFID_rs_i || IDEX_rt_i==IFID_rt_i).
- FSM states: RUN, MUL.
- RUN evaluates its conditions in this priority order (first match wins):
  1. load_use: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, Flush_o=0. State stays RUN. A branch or jump in ID is ignored this cycle and re-evaluated next cycle.
  2. Branch_taken_i or Jump_i: PC_Write_o=1, IFID_Write_o=1, Flush_o=1.
     - If Mul_start_i is also set (malformed), treat it as a branch: Mul_start_i is ignored.
  3. Mul_start_i: the multiply advances normally this cycle with all enables at 1. Next state is MUL, with cnt loaded to MUL_LAT-1.
  4. Otherwise all enables are 1, Flush_o=0, IDEX_Bubble_o=0, IDEX_Hold_o=0.
- MUL:
  - Outputs: PC_Write_o=0, IFID_Write_o=0, IDEX_Hold_o=1, Flush_o=0, IDEX_Bubble_o=0.
  - All hazard inputs are ignored.
  - cnt decrements each cycle. When cnt==1, next state is RUN.
  - The MUL state lasts MUL_LAT-1 cycles.
- Flush_o is never asserted in a cycle where IFID_Write_o=0.
- Counters:
  - stall_cnt increments on every non-reset cycle with PC_Write_o=0.
  - flush_cnt increments on every non-reset cycle with Flush_o=1.
  - Both saturate at all-ones.

## Timing
- Reset (rst_i high at posedge):
  - Next state RUN, cnt=0, both counters 0.
  - While rst_i is high, outputs are forced: PC_Write_o=0, IFID_Write_o=1, Flush_o=1, IDEX_Bubble_o=1, IDEX_Hold_o=0. This zeroes IF/ID.
- Reset mid-MUL aborts the stall; the first cycle after reset is in RUN.
- Load-use costs exactly 1 bubble cycle, because the hazard clears once the bubble reaches EX.
- A taken branch costs 1 flushed slot.
- A multiply costs MUL_LAT-1 stall cycles.
- Back-to-back multiplies: the second multiply is held in ID during MUL. When the FSM returns to RUN, that multiply is seen via Mul_start_i and starts a new MUL period.
- Load-use followed by branch on the load result: 1 stall cycle, then the flush in the following cycle.
- cnt width is $clog2(MUL_LAT).

## Structure
- Shared package `cpu_pkg` holds:
  - state typedef {RUN, MUL}
  - REG_ZERO = 5'd0
  - NOP_INST = 32'b0
- One sub-module, `sat_counter` (CNT_W, inc, clear), instantiated twice for the performance counters.
- The hazard compare and FSM stay in the top module.

## Test plan
- Load then dependent instruction: IDEX_MemRead_i=1, IDEX_rt_i=8, IFID_rs_i=8 for one cycle.
  - Required: PC_Write_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 for exactly 1 cycle; stall_cnt_o=1.
- Load with IDEX_rt_i=0 matching IFID_rt_i=0: no stall (all enables 1).
- Branch_taken_i=1 for 1 cycle.
  - Required: Flush_o=1, PC_Write_o=1, IFID_Write_o=1; flush_cnt_o=1.
- Branch_taken_i=1 together with a load_use match.
  - Required: stall only, Flush_o=0.
  - Then, with load_use deasserted and Branch_taken_i still 1: Flush_o=1 in the next cycle.
- Mul_start_i=1 pulse with MUL_LAT=4.
  - Required: 3 cycles of PC_Write_o=0 and IDEX_Hold_o=1, then RUN; stall_cnt_o=3.
  - Repeat the test with rst_i asserted during the 2nd MUL cycle. Required: the next cycle is RUN and both counters are 0.
- Force counters near saturation (CNT_W=4), then apply 20 stall cycles.
  - Required: stall_cnt_o holds at 4'hF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline sequencing states and architectural constants.
package cpu_pkg;

    // Sequencing states of the hazard/stall controller
    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    // Register zero is hard-wired; a load targeting it never creates a hazard
    localparam logic [4:0]  REG_ZERO = 5'd0;

    // IF/ID is cleared to this encoding when flushed
    localparam logic [31:0] NOP_INST = 32'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear has priority; once all-ones the counter holds instead of wrapping
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch/jump flushes,
// multi-cycle multiply occupancy of EX, plus stall/flush performance counters.
module hazard_stall_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic [4:0]       IFID_rs_i,
    input  logic [4:0]       IFID_rt_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_rt_i,
    input  logic             Branch_taken_i,
    input  logic             Jump_i,
    input  logic             Mul_start_i,
    output logic             PC_Write_o,
    output logic             IFID_Write_o,
    output logic             Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             IDEX_Hold_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Down-counter only has to hold MUL_LAT-1
    localparam int              CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0]   CNT_INIT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          load_use;
    logic          redirect;

    assign load_use = IDEX_MemRead_i && (IDEX_rt_i != REG_ZERO) &&
                      ((IDEX_rt_i == IFID_rs_i) || (IDEX_rt_i == IFID_rt_i));
    assign redirect = Branch_taken_i || Jump_i;

    // State and multiply occupancy counter; a load-use or redirect in ID
    // pre-empts a multiply start (a malformed branch+mul is treated as branch)
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!load_use && !redirect && Mul_start_i) begin
                        state <= MUL;
                        cnt   <= CNT_INIT;
                    end
                end
                MUL: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Control outputs: combinational so they settle before the edge that
    // IF/ID and ID/EX sample; reset forces a flush so IF/ID loads a NOP
    always_comb begin
        PC_Write_o    = 1'b1;
        IFID_Write_o  = 1'b1;
        Flush_o       = 1'b0;
        IDEX_Bubble_o = 1'b0;
        IDEX_Hold_o   = 1'b0;
        if (rst_i) begin
            PC_Write_o    = 1'b0;
            Flush_o       = 1'b1;
            IDEX_Bubble_o = 1'b1;
        end else if (state == MUL) begin
            PC_Write_o   = 1'b0;
            IFID_Write_o = 1'b0;
            IDEX_Hold_o  = 1'b1;
        end else if (load_use) begin
            PC_Write_o    = 1'b0;
            IFID_Write_o  = 1'b0;
            IDEX_Bubble_o = 1'b1;
        end else if (redirect) begin
            Flush_o = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (rst_i),
        .inc   (!PC_Write_o),
        .count (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (rst_i),
        .inc   (Flush_o),
        .count (flush_cnt_o)
    );

endmodule
